dot_acc: RTL
============

# dot_acc

Signed dot-product accumulator directly downstream of the 8x8 Dadda multiplier (`dadda_8`). Accepts one signed 16-bit product per cycle over a valid/ready handshake and sums a vector of products into a sign-extended accumulator. It presents the final sum on a held output handshake. A vector ends on an explicit last flag or when it reaches a maximum length.

## Interface
- `PROD_W`, 16: product width; matches the multiplier output width N+M.
- `ACC_W`, 24: accumulator and result width; must be at least `PROD_W`+1.
- `MAX_LEN`, 16: maximum products per vector; the vector auto-terminates at this count.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `prod_valid` input 1: `prod_i` carries a product.
- `prod_i` input `PROD_W`: signed product from the multiplier.
- `prod_last` input 1: this product is the last one in the vector; qualified by the transfer.
- `prod_ready` output 1: the block accepts a product this cycle.
- `flush` input 1: abandon the current vector or the pending result.
- `acc_valid` output 1: the result is available.
- `acc_o` output `ACC_W`: signed vector sum.
- `acc_len` output `$clog2(MAX_LEN+1)`: number of products summed into `acc_o`.
- `acc_ovf` output 1: overflow occurred in this vector (sticky per vector).
- `out_ready` input 1: the consumer takes the result.

## Operation
- The FSM has two states.
  - ACC: `prod_ready`=1, `acc_valid`=0.
  - DONE: `prod_ready`=0, `acc_valid`=1.
- Transfer occurs when `prod_valid` && `prod_ready`. On transfer:
  - `acc` ← `acc` + sign-extend(`prod_i`).
  - `cnt` ← `cnt`+1.
  - The overflow flag ORs in a signed-overflow detect on this add: both operand signs equal and the sum sign differs.
- Termination: a transfer with `prod_last`=1, or a transfer that brings `cnt` to `MAX_LEN`, loads `acc_o`/`acc_len`/`acc_ovf` from the post-add values and moves the FSM to DONE.
- DONE with `out_ready`=1:
  - FSM returns to ACC.
  - `acc`, `cnt` and the overflow flag clear to 0.
- `acc_o`, `acc_len` and `acc_ovf` are stable throughout DONE.
- `flush`=1 in any state:
  - FSM goes to ACC; `acc`, `cnt` and the flag clear.
  - `acc_valid` drops on the next cycle.
  - A product offered in the same cycle is discarded; flush wins over transfer.
  - A pending result is discarded even when `out_ready`=1.
- `prod_valid` with no transfer (state DONE) has no effect. The upstream stage must hold its product.
- A zero-length vector is impossible; termination is only reached through a transfer.

## Timing
- Reset (`rst_n`=0 at an edge) gives:
  - state ACC;
  - `acc`=0, `cnt`=0;
  - `acc_valid`=0, `acc_o`=0, `acc_len`=0, `acc_ovf`=0.
- `prod_ready` is forced to 0 while `rst_n`=0.
- Reset mid-vector or in DONE discards everything. No result is emitted.
- Latency: a terminating transfer at edge k makes `acc_valid`=1 in the cycle after edge k.
- Throughput: one product per cycle within a vector.
- There is one bubble cycle per vector: the DONE→ACC edge does not accept a product. Minimum vector period is length+1 cycles.
- All outputs are registered except `prod_ready`, which is decoded from the state and `rst_n`.

## Configuration
- `DOT_ACC_SAT_EN` defined: on signed overflow the add result clamps.
  - Positive overflow gives 2^(ACC_W-1)-1; negative overflow gives -2^(ACC_W-1).
  - The flag sets. Later adds continue from the clamped value.
- `DOT_ACC_SAT_EN` undefined: two's-complement wraparound modulo 2^ACC_W. The flag still sets on overflow.

## Test plan
- Products 12, -12, 16384 (last on the third) → `acc_valid` in the cycle after the third transfer, `acc_o`=16384, `acc_len`=3, `acc_ovf`=0.
- 16 consecutive products of 16129 with `prod_last`=0 → auto-terminate after the 16th transfer, `acc_o`=258064, `acc_len`=16.
- `ACC_W`=18, eight products of 16384 (last on the eighth) → with `DOT_ACC_SAT_EN`: `acc_o`=131071, `acc_ovf`=1; without: `acc_o`=-131072, `acc_ovf`=1.
- Result ready with `out_ready`=0 for 5 cycles → `acc_valid`, `acc_o` and `acc_len` hold and `prod_ready`=0. Then `out_ready`=1 → next cycle `acc_valid`=0, `prod_ready`=1, and the next vector -16256 (last) yields -16256.
- Two products 1000 accepted, then `flush` together with a valid third product 5 → no result. The next vector 7 (last) yields `acc_o`=7, `acc_len`=1.
- `rst_n`=0 for one cycle after two products of -250 → all outputs 0 and `prod_ready`=0 during reset. The next vector 1000 (last) yields 1000, `acc_len`=1.

Source files
------------

// File: rtl/dot_acc.sv
// Signed dot-product accumulator: sums a vector of signed products and holds the result on a valid/ready output.
// Define DOT_ACC_SAT_EN to clamp on signed overflow; otherwise the accumulator wraps.
module dot_acc #(
    parameter int PROD_W  = 16,
    parameter int ACC_W   = 24,
    parameter int MAX_LEN = 16,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     prod_valid,
    input  logic signed [PROD_W-1:0] prod_i,
    input  logic                     prod_last,
    output logic                     prod_ready,
    input  logic                     flush,
    output logic                     acc_valid,
    output logic signed [ACC_W-1:0]  acc_o,
    output logic [LEN_W-1:0]         acc_len,
    output logic                     acc_ovf,
    input  logic                     out_ready
);

    typedef enum logic {S_ACC, S_DONE} state_e;

    state_e                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0]        cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;
    logic signed [ACC_W-1:0] res_acc_q, res_acc_d;
    logic [LEN_W-1:0]        res_len_q, res_len_d;
    logic                    res_ovf_q, res_ovf_d;

    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] sum_raw;
    logic signed [ACC_W-1:0] sum;
    logic                    add_ovf;
    logic [LEN_W-1:0]        cnt_inc;
    logic                    xfer;
    logic                    term;

    assign prod_ready = rst_n && (state_q == S_ACC);
    assign acc_valid  = (state_q == S_DONE);
    assign acc_o      = res_acc_q;
    assign acc_len    = res_len_q;
    assign acc_ovf    = res_ovf_q;

    // Overflow only when both addends share a sign and the sum's sign differs from it.
    always_comb begin
        prod_ext = {{(ACC_W-PROD_W){prod_i[PROD_W-1]}}, prod_i};
        sum_raw  = acc_q + prod_ext;
        add_ovf  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) && (sum_raw[ACC_W-1] != acc_q[ACC_W-1]);
`ifdef DOT_ACC_SAT_EN
        if (add_ovf)
            sum = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            sum = sum_raw;
`else
        sum = sum_raw;
`endif
        cnt_inc = cnt_q + LEN_W'(1);
        xfer    = prod_valid && prod_ready;
        term    = xfer && (prod_last || (cnt_inc == LEN_W'(MAX_LEN)));
    end

    // NOTE: every next-state signal gets its default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        res_acc_d = res_acc_q;
        res_len_d = res_len_q;
        res_ovf_d = res_ovf_q;

        if (flush) begin
            state_d = S_ACC;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                S_ACC: begin
                    if (xfer) begin
                        acc_d = sum;
                        cnt_d = cnt_inc;
                        ovf_d = ovf_q | add_ovf;
                    end
                    if (term) begin
                        res_acc_d = sum;
                        res_len_d = cnt_inc;
                        res_ovf_d = ovf_q | add_ovf;
                        state_d   = S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_ACC;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: state_d = S_ACC;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_ACC;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            res_acc_q <= '0;
            res_len_q <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            res_acc_q <= res_acc_d;
            res_len_q <= res_len_d;
            res_ovf_q <= res_ovf_d;
        end
    end

endmodule
